// File: rtl/bit_permute_pkg.sv
// Shared types and sizing helpers for the table-driven bit permutation engine.
package bit_permute_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_e;

    // Word widths of the DES permutation tables (IP/PC1/E/P sides).
    typedef enum int {
        DES_W32 = 32,
        DES_W48 = 48,
        DES_W56 = 56,
        DES_W64 = 64
    } des_w_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int addr_w(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

    function automatic int steps(input int out_w, input int lanes);
        return (out_w + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/bit_permute_tbl_rom.sv
// Synchronous index-table memory, 1-cycle read latency; word 0 sits in the MSBs of INIT.
// With BIT_PERMUTE_TBL_WR_EN it becomes a 1R1W RAM with write-first read of the same word.
module bit_permute_tbl_rom #(
    parameter int                     DEPTH = 8,
    parameter int                     WIDTH = 56,
    parameter int                     AW    = 3,
    parameter logic [DEPTH*WIDTH-1:0] INIT  = '0
) (
    input  logic             clk_i,
    input  logic             ce_i,
    input  logic [AW-1:0]    addr_i,
`ifdef BIT_PERMUTE_TBL_WR_EN
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
`endif
    output logic [WIDTH-1:0] rdata_o
);

    typedef logic [WIDTH-1:0] mem_t [DEPTH];

    function automatic mem_t unpack_init();
        mem_t m;
        for (int k = 0; k < DEPTH; k++) m[k] = INIT[(DEPTH-1-k)*WIDTH +: WIDTH];
        return m;
    endfunction

    logic [WIDTH-1:0] rdata_q;

`ifdef BIT_PERMUTE_TBL_WR_EN
    // Power-up image only; contents are never touched by reset.
    mem_t mem_q = unpack_init();

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (ce_i) rdata_q <= (we_i && (waddr_i == addr_i)) ? wdata_i : mem_q[addr_i];
    end
`else
    localparam mem_t ROM = unpack_init();

    always_ff @(posedge clk_i) begin
        if (ce_i) rdata_q <= ROM[addr_i];
    end
`endif

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bit_permute_engine.sv
// Table-driven gather (mode 0) / scatter (mode 1) bit permutation, LANES 1-based MSB-first entries per cycle.
// Table image is the TBL_INIT parameter; BIT_PERMUTE_TBL_WR_EN adds an IDLE-only table write port.
module bit_permute_engine
    import bit_permute_pkg::*;
#(
    parameter int IN_W  = DES_W64,
    parameter int OUT_W = DES_W64,
    parameter int LANES = 8,
    parameter int IDX_W = 7,
    parameter logic [steps(OUT_W, LANES)*LANES*IDX_W-1:0] TBL_INIT = '0
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
`ifdef BIT_PERMUTE_TBL_WR_EN
    input  logic             tbl_we,
    input  logic [addr_w(steps(OUT_W, LANES))-1:0] tbl_addr,
    input  logic [LANES*IDX_W-1:0] tbl_wdata,
`endif
    input  logic             mode,
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             perm_err
);

    localparam int   STEPS  = steps(OUT_W, LANES);
    localparam int   AW     = addr_w(STEPS);
    localparam int   WW     = LANES * IDX_W;
    localparam int   INB    = addr_w(IN_W);
    localparam int   OUTB   = addr_w(OUT_W);
    localparam logic INV_OK = (IN_W == OUT_W);

    fsm_e             state_q, state_d;
    logic [AW-1:0]    step_q, step_d;
    logic [IN_W-1:0]  din_q;
    logic             mode_q;
    logic [OUT_W-1:0] dout_q, dout_d;
    logic             err_q, err_d;
    logic             accept;
    logic             rd_ce;
    logic [AW-1:0]    rd_addr;
    logic [WW-1:0]    rd_word;

    logic [LANES-1:0] lane_wr, lane_err, lane_bit;
    logic [OUTB-1:0]  lane_pos [LANES];

    bit_permute_tbl_rom #(
        .DEPTH (STEPS),
        .WIDTH (WW),
        .AW    (AW),
        .INIT  (TBL_INIT)
    ) u_tbl (
        .clk_i   (ap_clk),
        .ce_i    (rd_ce),
        .addr_i  (rd_addr),
`ifdef BIT_PERMUTE_TBL_WR_EN
        .we_i    (tbl_we && (state_q == IDLE)),
        .waddr_i (tbl_addr),
        .wdata_i (tbl_wdata),
`endif
        .rdata_o (rd_word)
    );

    // rd_word holds the table word for step_q; lanes past OUT_W are masked entirely.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [31:0] idx, ent;
        logic        live, ent_ok;

        assign idx    = 32'(step_q) * 32'(LANES) + 32'(l);
        assign ent    = 32'(rd_word[(LANES-1-l)*IDX_W +: IDX_W]);
        assign live   = idx < 32'(OUT_W);
        assign ent_ok = (ent != 32'd0) && (ent <= 32'(IN_W));

        assign lane_wr[l]  = live && ent_ok;
        assign lane_err[l] = live && !ent_ok;
        assign lane_pos[l] = mode_q ? OUTB'(32'(IN_W) - ent) : OUTB'(32'(OUT_W - 1) - idx);
        assign lane_bit[l] = mode_q ? din_q[INB'(32'(OUT_W - 1) - idx)] : din_q[INB'(32'(IN_W) - ent)];
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        dout_d  = dout_q;
        err_d   = err_q;
        accept  = 1'b0;
        rd_ce   = 1'b0;
        rd_addr = '0;
        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    accept  = 1'b1;
                    rd_ce   = 1'b1;
                    step_d  = '0;
                    dout_d  = '0;
                    err_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Ascending lane order makes the later table entry win on duplicate scatter targets.
                for (int l = 0; l < LANES; l++) begin
                    if (lane_wr[l]) dout_d[lane_pos[l]] = lane_bit[l];
                end
                err_d = err_q | (|lane_err);
                if (step_q == AW'(STEPS - 1)) begin
                    state_d = DONE;
                end else begin
                    step_d  = step_q + 1'b1;
                    rd_ce   = 1'b1;
                    rd_addr = step_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            din_q   <= '0;
            mode_q  <= 1'b0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            if (accept) begin
                din_q  <= din;
                mode_q <= mode & INV_OK;
            end
        end
    end

    assign ap_done  = (state_q == DONE);
    assign ap_ready = (state_q == DONE);
    assign ap_idle  = (state_q == IDLE) && !ap_start;
    assign dout     = dout_q;
    assign perm_err = err_q;

endmodule
